ederah_axi_mem_responder: RTL and testbench

- AXI4 slave responder: the memory end of the kernel's m00_axi master port (AW/W/B write path, AR/R read path, same reduced signal subset, no IDs, no burst type, INCR only).
- Backed by on-chip simple-dual-port RAM, one line per beat.
- Used as device memory for kernel-level simulation and for on-chip loopback builds. Holds NFA data, query blocks and result lines at byte addresses.
- Write and read channels run concurrently and independently.

---
 rtl/ederah_axi_pkg.sv | 23 ++
 rtl/ederah_bram_sdp.sv | 29 ++
 rtl/ederah_axi_mem_responder.sv | 201 ++++++++++++++++++++
 tb/tb_ederah_axi_mem_responder.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/ederah_axi_pkg.sv
// Shared types and helpers for the AXI memory responder: FSM state encodings,
// the beat-offset width helper and the AXI response code.
package ederah_axi_pkg;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_DATA = 2'd1,
    W_RESP = 2'd2
  } wr_state_t;

  typedef enum logic {
    R_IDLE  = 1'b0,
    R_BURST = 1'b1
  } rd_state_t;

  localparam logic [1:0] RESP_OKAY = 2'b00;

  // Number of byte-offset bits inside one beat.
  function automatic int lb_of(input int data_w);
    return $clog2(data_w / 8);
  endfunction

endpackage

// File: rtl/ederah_bram_sdp.sv
// Simple dual-port RAM: one byte-enabled write port, one registered read port.
// A same-address read and write in one cycle returns the old contents.
module ederah_bram_sdp #(
  parameter int DATA_W     = 512,
  parameter int DEPTH_LOG2 = 10
) (
  input  logic                    clk,
  input  logic                    we,
  input  logic [DEPTH_LOG2-1:0]   waddr,
  input  logic [DATA_W-1:0]       wdata,
  input  logic [DATA_W/8-1:0]     wstrb,
  input  logic                    re,
  input  logic [DEPTH_LOG2-1:0]   raddr,
  output logic [DATA_W-1:0]       rdata
);

  logic [DATA_W-1:0] mem [2**DEPTH_LOG2];

  // Read sampled before the write lands in the same block: read-first.
  always_ff @(posedge clk) begin
    if (re) rdata <= mem[raddr];
    if (we) begin
      for (int b = 0; b < DATA_W / 8; b++) begin
        if (wstrb[b]) mem[waddr][b*8 +: 8] <= wdata[b*8 +: 8];
      end
    end
  end

endmodule

// File: rtl/ederah_axi_mem_responder.sv
// AXI4 slave memory responder (INCR only, no IDs) backed by a simple-dual-port
// RAM; independent write and read FSMs, 2-entry read output FIFO.
module ederah_axi_mem_responder
  import ederah_axi_pkg::*;
#(
  parameter int C_S_AXI_ADDR_WIDTH = 64,
  parameter int C_S_AXI_DATA_WIDTH = 512,
  parameter int C_MEM_DEPTH_LOG2   = 10
) (
  input  logic                            data_clk,
  input  logic                            data_rst_n,
  input  logic                            s_axi_awvalid,
  output logic                            s_axi_awready,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s_axi_awaddr,
  input  logic [7:0]                      s_axi_awlen,
  input  logic                            s_axi_wvalid,
  output logic                            s_axi_wready,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   s_axi_wdata,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] s_axi_wstrb,
  input  logic                            s_axi_wlast,
  output logic                            s_axi_bvalid,
  input  logic                            s_axi_bready,
  input  logic                            s_axi_arvalid,
  output logic                            s_axi_arready,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s_axi_araddr,
  input  logic [7:0]                      s_axi_arlen,
  output logic                            s_axi_rvalid,
  input  logic                            s_axi_rready,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   s_axi_rdata,
  output logic                            s_axi_rlast,
  output logic                            err_wlast,
  output logic [31:0]                     wr_bursts,
  output logic [31:0]                     rd_bursts
);

  localparam int LB = lb_of(C_S_AXI_DATA_WIDTH);
  localparam int AW = C_MEM_DEPTH_LOG2;
  localparam logic [AW-1:0] IDX_ONE = 1;

  logic          ready_en;
  logic [AW-1:0] aw_idx, ar_idx;
  logic          unused_addr;

  assign aw_idx      = s_axi_awaddr[AW+LB-1:LB];
  assign ar_idx      = s_axi_araddr[AW+LB-1:LB];
  assign unused_addr = ^{s_axi_awaddr, s_axi_araddr};

  // Keeps both address channels closed while reset is held.
  always_ff @(posedge data_clk or negedge data_rst_n) begin
    if (!data_rst_n) ready_en <= 1'b0;
    else             ready_en <= 1'b1;
  end

  wr_state_t     wr_state, wr_next;
  logic [AW-1:0] wr_idx;
  logic [7:0]    wr_cnt;
  logic          w_hs;

  always_comb begin
    s_axi_awready = 1'b0;
    s_axi_wready  = 1'b0;
    s_axi_bvalid  = 1'b0;
    wr_next       = wr_state;
    case (wr_state)
      W_IDLE: begin
        s_axi_awready = ready_en;
        if (s_axi_awvalid && ready_en) wr_next = W_DATA;
      end
      W_DATA: begin
        s_axi_wready = 1'b1;
        if (s_axi_wvalid && wr_cnt == 8'd0) wr_next = W_RESP;
      end
      W_RESP: begin
        s_axi_bvalid = 1'b1;
        if (s_axi_bready) wr_next = W_IDLE;
      end
      default: wr_next = W_IDLE;
    endcase
  end

  assign w_hs = s_axi_wvalid && s_axi_wready;

  // The beat count ends the burst; wlast is only audited.
  always_ff @(posedge data_clk or negedge data_rst_n) begin
    if (!data_rst_n) begin
      wr_state  <= W_IDLE;
      wr_idx    <= '0;
      wr_cnt    <= '0;
      err_wlast <= 1'b0;
      wr_bursts <= '0;
    end else begin
      wr_state <= wr_next;
      if (s_axi_awvalid && s_axi_awready) begin
        wr_idx <= aw_idx;
        wr_cnt <= s_axi_awlen;
      end else if (w_hs) begin
        wr_idx <= wr_idx + IDX_ONE;
        wr_cnt <= wr_cnt - 8'd1;
        if (s_axi_wlast != (wr_cnt == 8'd0)) err_wlast <= 1'b1;
      end
      if (s_axi_bvalid && s_axi_bready) wr_bursts <= wr_bursts + 32'd1;
    end
  end

  rd_state_t                     rd_state, rd_next;
  logic [AW-1:0]                 rd_idx, issue_idx;
  logic [7:0]                    rd_cnt;
  logic                          ar_hs, issue, issue_last;
  logic                          inflight, inflight_last;
  logic [C_S_AXI_DATA_WIDTH-1:0] ram_rdata;
  logic [C_S_AXI_DATA_WIDTH-1:0] fifo_data [2];
  logic [1:0]                    fifo_last;
  logic                          fifo_wp, fifo_rp, pop;
  logic [1:0]                    fifo_cnt, occ_after;

  assign s_axi_rvalid = fifo_cnt != 2'd0;
  assign pop          = s_axi_rvalid && s_axi_rready;
  assign occ_after    = fifo_cnt - {1'b0, pop};
  assign s_axi_rdata  = s_axi_rvalid ? fifo_data[fifo_rp] : '0;
  assign s_axi_rlast  = s_axi_rvalid && fifo_last[fifo_rp];

  // Beat 0 is issued in the AR handshake cycle so the first rvalid lands two
  // cycles after it; the slot freed by this cycle's pop counts as room.
  always_comb begin
    s_axi_arready = 1'b0;
    ar_hs         = 1'b0;
    issue         = 1'b0;
    issue_last    = 1'b0;
    issue_idx     = rd_idx;
    rd_next       = rd_state;
    case (rd_state)
      R_IDLE: begin
        s_axi_arready = ready_en && fifo_cnt == 2'd0 && !inflight;
        if (s_axi_arvalid && s_axi_arready) begin
          ar_hs      = 1'b1;
          issue      = 1'b1;
          issue_idx  = ar_idx;
          issue_last = s_axi_arlen == 8'd0;
          if (s_axi_arlen != 8'd0) rd_next = R_BURST;
        end
      end
      R_BURST: begin
        issue      = (occ_after + {1'b0, inflight}) < 2'd2;
        issue_last = rd_cnt == 8'd0;
        if (issue && issue_last) rd_next = R_IDLE;
      end
      default: rd_next = R_IDLE;
    endcase
  end

  always_ff @(posedge data_clk or negedge data_rst_n) begin
    if (!data_rst_n) begin
      rd_state      <= R_IDLE;
      rd_idx        <= '0;
      rd_cnt        <= '0;
      inflight      <= 1'b0;
      inflight_last <= 1'b0;
      fifo_cnt      <= '0;
      fifo_wp       <= 1'b0;
      fifo_rp       <= 1'b0;
      rd_bursts     <= '0;
    end else begin
      rd_state <= rd_next;
      if (ar_hs) begin
        rd_idx <= ar_idx + IDX_ONE;
        rd_cnt <= s_axi_arlen - 8'd1;
      end else if (issue) begin
        rd_idx <= rd_idx + IDX_ONE;
        rd_cnt <= rd_cnt - 8'd1;
      end
      inflight <= issue;
      if (issue) inflight_last <= issue_last;
      fifo_cnt <= fifo_cnt + {1'b0, inflight} - {1'b0, pop};
      if (inflight) fifo_wp <= ~fifo_wp;
      if (pop) fifo_rp <= ~fifo_rp;
      if (pop && s_axi_rlast) rd_bursts <= rd_bursts + 32'd1;
    end
  end

  always_ff @(posedge data_clk) begin
    if (inflight) begin
      fifo_data[fifo_wp] <= ram_rdata;
      fifo_last[fifo_wp] <= inflight_last;
    end
  end

  ederah_bram_sdp #(
    .DATA_W     (C_S_AXI_DATA_WIDTH),
    .DEPTH_LOG2 (C_MEM_DEPTH_LOG2)
  ) u_ram (
    .clk   (data_clk),
    .we    (w_hs),
    .waddr (wr_idx),
    .wdata (s_axi_wdata),
    .wstrb (s_axi_wstrb),
    .re    (issue),
    .raddr (issue_idx),
    .rdata (ram_rdata)
  );

endmodule

// File: tb/tb_ederah_axi_mem_responder.sv
// Scoreboard bench for ederah_axi_mem_responder: a shadow memory model predicts
// every read beat; expected beats are queued at AR time and popped on R handshakes.
module tb_ederah_axi_mem_responder;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         awvalid = 1'b0, awready;
  logic [63:0]  awaddr = '0;
  logic [7:0]   awlen = '0;
  logic         wvalid = 1'b0, wready, wlast = 1'b0;
  logic [511:0] wdata = '0;
  logic [63:0]  wstrb = '0;
  logic         bvalid, bready = 1'b0;
  logic         arvalid = 1'b0, arready;
  logic [63:0]  araddr = '0;
  logic [7:0]   arlen = '0;
  logic         rvalid, rready = 1'b0, rlast;
  logic [511:0] rdata;
  logic         err_wlast;
  logic [31:0]  wr_bursts, rd_bursts;

  typedef struct packed { logic [511:0] data; logic last; } beat_t;
  beat_t        sb [$];
  logic [511:0] model [1024];
  logic [511:0] wbuf  [16];
  int           n_checks = 0, n_pass = 0;
  int           exp_wr = 0, exp_rd = 0;
  logic         exp_err = 1'b0;

  always #5 clk = ~clk;

  ederah_axi_mem_responder dut (
    .data_clk(clk), .data_rst_n(rst_n),
    .s_axi_awvalid(awvalid), .s_axi_awready(awready), .s_axi_awaddr(awaddr), .s_axi_awlen(awlen),
    .s_axi_wvalid(wvalid), .s_axi_wready(wready), .s_axi_wdata(wdata), .s_axi_wstrb(wstrb),
    .s_axi_wlast(wlast), .s_axi_bvalid(bvalid), .s_axi_bready(bready),
    .s_axi_arvalid(arvalid), .s_axi_arready(arready), .s_axi_araddr(araddr), .s_axi_arlen(arlen),
    .s_axi_rvalid(rvalid), .s_axi_rready(rready), .s_axi_rdata(rdata), .s_axi_rlast(rlast),
    .err_wlast(err_wlast), .wr_bursts(wr_bursts), .rd_bursts(rd_bursts)
  );

  task automatic do_write(input logic [63:0] addr, input int len, input logic [63:0] strb,
                          input int last_beat);
    int t, line;
    @(posedge clk); #1;
    awvalid = 1'b1; awaddr = addr; awlen = 8'(len);
    t = 0; @(negedge clk);
    while (!awready && t < 50) begin @(negedge clk); t++; end
    if (!awready) begin n_checks++; $display("FAIL aw_timeout awready=%0b required=1", awready); end
    @(posedge clk); #1 awvalid = 1'b0;
    for (int k = 0; k <= len; k++) begin
      wvalid = 1'b1; wdata = wbuf[k]; wstrb = strb; wlast = (k == last_beat);
      t = 0; @(negedge clk);
      while (!wready && t < 50) begin @(negedge clk); t++; end
      if (!wready) begin n_checks++; $display("FAIL w_timeout beat=%0d wready=0 required=1", k); end
      @(posedge clk); #1;
      line = (int'(addr[15:6]) + k) % 1024;
      for (int b = 0; b < 64; b++) if (strb[b]) model[line][b*8 +: 8] = wbuf[k][b*8 +: 8];
    end
    wvalid = 1'b0; wlast = 1'b0;
    if (last_beat != len) exp_err = 1'b1;
    n_checks++;
    if (bvalid !== 1'b1) $display("FAIL b_latency bvalid=%0b required=1", bvalid);
    else n_pass++;
    bready = 1'b1;
    @(posedge clk); #1 bready = 1'b0;
    exp_wr++;
    n_checks++;
    if (bvalid !== 1'b0) $display("FAIL b_drop bvalid=%0b required=0", bvalid);
    else n_pass++;
    n_checks++;
    if (wr_bursts !== 32'(exp_wr)) $display("FAIL wr_bursts got=%0d required=%0d", wr_bursts, exp_wr);
    else n_pass++;
    n_checks++;
    if (err_wlast !== exp_err) $display("FAIL err_wlast got=%0b required=%0b", err_wlast, exp_err);
    else n_pass++;
  endtask

  // pat[iter%4] drives rready; abort_at>=0 pulls reset while that beat is presented;
  // exp_last_iter>=0 also checks first-rvalid latency and the iteration of the final beat.
  task automatic do_read(input logic [63:0] addr, input int len, input logic [3:0] pat,
                         input int abort_at, input int exp_last_iter);
    int t, hs, last_iter;
    beat_t e;
    logic v, l;
    logic [511:0] d;
    for (int k = 0; k <= len; k++) begin
      e.data = model[(int'(addr[15:6]) + k) % 1024];
      e.last = (k == len);
      sb.push_back(e);
    end
    @(posedge clk); #1;
    arvalid = 1'b1; araddr = addr; arlen = 8'(len);
    t = 0; @(negedge clk);
    while (!arready && t < 50) begin @(negedge clk); t++; end
    if (!arready) begin n_checks++; $display("FAIL ar_timeout arready=%0b required=1", arready); end
    @(posedge clk); #1 arvalid = 1'b0;
    hs = 0; last_iter = -1;
    for (int iter = 0; iter < 300 && sb.size() > 0; iter++) begin
      rready = pat[iter % 4];
      if (abort_at >= 0 && hs == abort_at && rvalid) begin
        rst_n = 1'b0; #1;
        n_checks++;
        if (rvalid !== 1'b0) $display("FAIL rst_async rvalid=%0b required=0", rvalid);
        else n_pass++;
        sb.delete(); rready = 1'b0;
        @(posedge clk); #1 rst_n = 1'b1;
        return;
      end
      if (exp_last_iter >= 0 && iter < 2) begin
        n_checks++;
        if (rvalid !== (iter == 1)) $display("FAIL r_latency iter=%0d rvalid=%0b required=%0b", iter, rvalid, iter == 1);
        else n_pass++;
      end
      v = rvalid; d = rdata; l = rlast;
      @(posedge clk); #1;
      if (v && rready) begin
        e = sb.pop_front();
        n_checks++;
        if (d !== e.data) $display("FAIL rdata beat=%0d got=%h required=%h", hs, d[63:0], e.data[63:0]);
        else n_pass++;
        n_checks++;
        if (l !== e.last) $display("FAIL rlast beat=%0d got=%0b required=%0b", hs, l, e.last);
        else n_pass++;
        hs++; last_iter = iter;
      end else if (v) begin
        n_checks++;
        if (rvalid !== 1'b1 || rdata !== d || rlast !== l)
          $display("FAIL r_stall beat=%0d rvalid=%0b data=%h required_data=%h", hs, rvalid, rdata[63:0], d[63:0]);
        else n_pass++;
      end
    end
    rready = 1'b0;
    if (sb.size() != 0) begin
      n_checks++; $display("FAIL r_timeout beats_left=%0d required=0", sb.size());
      sb.delete();
    end
    exp_rd++;
    n_checks++;
    if (rd_bursts !== 32'(exp_rd)) $display("FAIL rd_bursts got=%0d required=%0d", rd_bursts, exp_rd);
    else n_pass++;
    if (exp_last_iter >= 0) begin
      n_checks++;
      if (last_iter != exp_last_iter) $display("FAIL r_throughput last_iter=%0d required=%0d", last_iter, exp_last_iter);
      else n_pass++;
    end
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if ({awready, arready, wready, bvalid, rvalid, rlast, err_wlast} !== 7'b0)
      $display("FAIL reset_ctrl got=%b required=0000000", {awready, arready, wready, bvalid, rvalid, rlast, err_wlast});
    else n_pass++;
    n_checks++;
    if (rdata !== '0 || wr_bursts !== 32'd0 || rd_bursts !== 32'd0)
      $display("FAIL reset_data rdata=%h wr=%0d rd=%0d required=0", rdata[63:0], wr_bursts, rd_bursts);
    else n_pass++;
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if (awready !== 1'b1 || arready !== 1'b1)
      $display("FAIL reset_release awready=%0b arready=%0b required=1", awready, arready);
    else n_pass++;
  endtask

  task automatic test_single();
    wbuf[0] = {16{32'hA5A5_0001}};
    do_write(64'h40, 0, 64'hFFFF_FFFF_FFFF_FFFF, 0);
    do_read(64'h40, 0, 4'b1111, -1, 1);
  endtask

  task automatic test_strobes();
    wbuf[0] = '1;
    do_write(64'h140, 0, 64'hFFFF_FFFF_FFFF_FFFF, 0);
    wbuf[0] = '0;
    do_write(64'h140, 0, 64'h0000_0000_0000_000F, 0);
    n_checks++;
    if (model[5] !== {{60{8'hFF}}, 32'h0}) $display("FAIL strobe_model got=%h required=ff..00000000", model[5][63:0]);
    else n_pass++;
    do_read(64'h140, 0, 4'b1111, -1, 1);
  endtask

  task automatic test_burst16();
    for (int k = 0; k < 16; k++) wbuf[k] = 512'(k);
    do_write(64'h1000, 15, 64'hFFFF_FFFF_FFFF_FFFF, 15);
    do_read(64'h1000, 15, 4'b1111, -1, 16);
  endtask

  task automatic test_backpressure();
    do_read(64'h1000, 15, 4'b1001, -1, -1);
  endtask

  task automatic test_wrap();
    for (int k = 0; k < 4; k++) wbuf[k] = {16{32'hC0DE_0000 + 32'(k)}};
    do_write(64'hFFC0, 3, 64'hFFFF_FFFF_FFFF_FFFF, 3);
    do_read(64'hFFC0, 3, 4'b1111, -1, 4);
    do_read(64'h0, 0, 4'b1111, -1, 1);
    do_read(64'h0000_0001_0000_0047, 0, 4'b1111, -1, 1);
  endtask

  task automatic test_wlast_err();
    for (int k = 0; k < 4; k++) wbuf[k] = {8{64'hBEEF_0000_0000_0000 + 64'(k)}};
    do_write(64'h2000, 3, 64'hFFFF_FFFF_FFFF_FFFF, 1);
    do_read(64'h2000, 3, 4'b1111, -1, 4);
  endtask

  task automatic test_reset_mid_read();
    do_read(64'h1000, 7, 4'b1111, 3, -1);
    exp_wr = 0; exp_rd = 0; exp_err = 1'b0;
    @(posedge clk); #1;
    n_checks++;
    if (arready !== 1'b1 || awready !== 1'b1 || rvalid !== 1'b0)
      $display("FAIL rst_recover arready=%0b awready=%0b rvalid=%0b required=1 1 0", arready, awready, rvalid);
    else n_pass++;
    n_checks++;
    if (wr_bursts !== 32'd0 || rd_bursts !== 32'd0 || err_wlast !== 1'b0)
      $display("FAIL rst_counters wr=%0d rd=%0d err=%0b required=0", wr_bursts, rd_bursts, err_wlast);
    else n_pass++;
    do_read(64'h1000, 3, 4'b1111, -1, 4);
  endtask

  initial begin
    test_reset();
    test_single();
    test_strobes();
    test_burst16();
    test_backpressure();
    test_wrap();
    test_wlast_err();
    test_reset_mid_read();
    repeat (2) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
